// File: rtl/multicycle_controller_pkg.sv
// Shared definitions for the multicycle controller and its ALU decoder:
// opcode constants, FSM state encoding, ALUOp and ALUControl codes, and
// the packed bundle of state-decoded control signals.
package multicycle_controller_pkg;

    localparam int unsigned OP_W     = 7;
    localparam int unsigned FUNCT3_W = 3;
    localparam int unsigned SEL_W    = 2;
    localparam int unsigned ALUOP_W  = 2;
    localparam int unsigned ALUCTL_W = 3;
    localparam int unsigned STATE_W  = 4;

    // Supported opcodes
    localparam logic [OP_W-1:0] OP_LW    = 7'b0000011;
    localparam logic [OP_W-1:0] OP_SW    = 7'b0100011;
    localparam logic [OP_W-1:0] OP_RTYPE = 7'b0110011;
    localparam logic [OP_W-1:0] OP_ITYPE = 7'b0010011;
    localparam logic [OP_W-1:0] OP_BEQ   = 7'b1100011;
    localparam logic [OP_W-1:0] OP_JAL   = 7'b1101111;

    // funct3 codes that select distinct ALU operations
    localparam logic [FUNCT3_W-1:0] F3_ADDSUB = 3'b000;
    localparam logic [FUNCT3_W-1:0] F3_SLT    = 3'b010;
    localparam logic [FUNCT3_W-1:0] F3_OR     = 3'b110;
    localparam logic [FUNCT3_W-1:0] F3_AND    = 3'b111;

    // ALU operations
    localparam logic [ALUCTL_W-1:0] ALU_ADD = 3'b000;
    localparam logic [ALUCTL_W-1:0] ALU_SUB = 3'b001;
    localparam logic [ALUCTL_W-1:0] ALU_AND = 3'b010;
    localparam logic [ALUCTL_W-1:0] ALU_OR  = 3'b011;
    localparam logic [ALUCTL_W-1:0] ALU_SLT = 3'b101;

    typedef enum logic [ALUOP_W-1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    // Control signals that depend only on the FSM state
    typedef struct packed {
        logic             pcupdate;
        logic             branch;
        logic             adrsrc;
        logic             memwrite;
        logic             irwrite;
        logic             regwrite;
        logic [SEL_W-1:0] resultsrc;
        logic [SEL_W-1:0] alusrca;
        logic [SEL_W-1:0] alusrcb;
        aluop_t           aluop;
    } ctrl_t;

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// alu_decoder: combinational ALUControl generation from ALUOp and the
// instruction fields.
//   op5       in  opcode bit 5 (distinguishes R-type from I-type)
//   funct3    in  instruction funct3
//   funct7b5  in  instruction bit 30
//   aluop     in  ALUOp from the controller FSM
//   alucontrol out ALU operation select
module alu_decoder
    import multicycle_controller_pkg::*;
(
    input  logic                op5,
    input  logic [FUNCT3_W-1:0] funct3,
    input  logic                funct7b5,
    input  aluop_t              aluop,
    output logic [ALUCTL_W-1:0] alucontrol
);

    always_comb begin
        alucontrol = ALU_ADD;
        case (aluop)
            ALUOP_ADD: alucontrol = ALU_ADD;
            ALUOP_SUB: alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // Subtract only for R-type with bit 30 set; addi ignores bit 30
                    F3_ADDSUB: alucontrol = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
                    F3_SLT:    alucontrol = ALU_SLT;
                    F3_OR:     alucontrol = ALU_OR;
                    F3_AND:    alucontrol = ALU_AND;
                    default:   alucontrol = ALU_ADD;
                endcase
            end
            default: alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore FSM sequencing a multicycle RISC-V datapath.
//   clk, reset      clock and synchronous active-high reset
//   op, funct3,     instruction fields from the instruction register
//   funct7b5
//   Zero            ALU zero flag (used for beq)
//   PCWrite         PC enable (PCUpdate or taken branch)
//   AdrSrc,MemWrite memory address select and write strobe
//   IRWrite         instruction register enable
//   RegWrite        register file write enable
//   ResultSrc       result mux select
//   ALUSrcA/B       ALU operand selects
//   ImmSrc          immediate format, decoded from op
//   ALUControl      ALU operation
module multicycle_controller
    import multicycle_controller_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic [OP_W-1:0]     op,
    input  logic [FUNCT3_W-1:0] funct3,
    input  logic                funct7b5,
    input  logic                Zero,
    output logic                PCWrite,
    output logic                AdrSrc,
    output logic                MemWrite,
    output logic                IRWrite,
    output logic                RegWrite,
    output logic [SEL_W-1:0]    ResultSrc,
    output logic [SEL_W-1:0]    ALUSrcA,
    output logic [SEL_W-1:0]    ALUSrcB,
    output logic [SEL_W-1:0]    ImmSrc,
    output logic [ALUCTL_W-1:0] ALUControl
);

    state_t state_q;
    state_t state_d;
    state_t cur;
    ctrl_t  ctrl;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and state-decoded controls; while reset is high the
    // outputs already present FETCH values so the datapath never sees a
    // stale mid-instruction strobe.
    always_comb begin
        state_d = S_FETCH;
        ctrl    = '0;
        cur     = reset ? S_FETCH : state_q;

        case (cur)
            S_FETCH: begin
                state_d        = S_DECODE;
                ctrl.irwrite   = 1'b1;
                ctrl.alusrcb   = 2'b10;
                ctrl.resultsrc = 2'b10;
                ctrl.pcupdate  = 1'b1;
            end
            S_DECODE: begin
                ctrl.alusrca = 2'b01;
                ctrl.alusrcb = 2'b01;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTER;
                    OP_ITYPE:     state_d = S_EXECUTEI;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                state_d      = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
                ctrl.alusrca = 2'b10;
                ctrl.alusrcb = 2'b01;
            end
            S_MEMREAD: begin
                state_d     = S_MEMWB;
                ctrl.adrsrc = 1'b1;
            end
            S_MEMWB: begin
                state_d        = S_FETCH;
                ctrl.resultsrc = 2'b01;
                ctrl.regwrite  = 1'b1;
            end
            S_MEMWRITE: begin
                state_d       = S_FETCH;
                ctrl.adrsrc   = 1'b1;
                ctrl.memwrite = 1'b1;
            end
            S_EXECUTER: begin
                state_d      = S_ALUWB;
                ctrl.alusrca = 2'b10;
                ctrl.aluop   = ALUOP_FUNCT;
            end
            S_EXECUTEI: begin
                state_d      = S_ALUWB;
                ctrl.alusrca = 2'b10;
                ctrl.alusrcb = 2'b01;
                ctrl.aluop   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                state_d       = S_FETCH;
                ctrl.regwrite = 1'b1;
            end
            S_BEQ: begin
                state_d      = S_FETCH;
                ctrl.alusrca = 2'b10;
                ctrl.aluop   = ALUOP_SUB;
                ctrl.branch  = 1'b1;
            end
            S_JAL: begin
                state_d       = S_ALUWB;
                ctrl.alusrca  = 2'b01;
                ctrl.alusrcb  = 2'b10;
                ctrl.pcupdate = 1'b1;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // Immediate format follows the opcode directly
    always_comb begin
        ImmSrc = 2'b00;
        case (op)
            OP_SW:   ImmSrc = 2'b01;
            OP_BEQ:  ImmSrc = 2'b10;
            OP_JAL:  ImmSrc = 2'b11;
            default: ImmSrc = 2'b00;
        endcase
    end

    alu_decoder u_alu_decoder (
        .op5        (op[5]),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .aluop      (ctrl.aluop),
        .alucontrol (ALUControl)
    );

    assign PCWrite   = ctrl.pcupdate | (ctrl.branch & Zero);
    assign AdrSrc    = ctrl.adrsrc;
    assign MemWrite  = ctrl.memwrite;
    assign IRWrite   = ctrl.irwrite;
    assign RegWrite  = ctrl.regwrite;
    assign ResultSrc = ctrl.resultsrc;
    assign ALUSrcA   = ctrl.alusrca;
    assign ALUSrcB   = ctrl.alusrcb;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: expected control vectors are
// pushed to a scoreboard queue as each cycle is driven and popped/compared
// on the following falling edge.
module tb_multicycle_controller;

    typedef enum int {
        T_FETCH, T_DECODE, T_MEMADR, T_MEMREAD, T_MEMWB, T_MEMWRITE,
        T_EXECUTER, T_EXECUTEI, T_ALUWB, T_BEQ, T_JAL
    } tst_t;

    typedef struct {
        logic [15:0] exp;
        string       tag;
    } sb_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;

    int  checks = 0;
    int  errors = 0;
    sb_t sbq[$];

    multicycle_controller dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .Zero       (Zero),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .RegWrite   (RegWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ImmSrc     (ImmSrc),
        .ALUControl (ALUControl)
    );

    always #5 clk = ~clk;

    // Reference outputs for a state given the current instruction inputs.
    // Vector: PCWrite AdrSrc MemWrite IRWrite RegWrite ResultSrc ALUSrcA ALUSrcB ImmSrc ALUControl
    function automatic logic [15:0] model(input tst_t st);
        logic       pcw = 1'b0, adr = 1'b0, mw = 1'b0, irw = 1'b0, rw = 1'b0;
        logic [1:0] res = 2'b00, sa = 2'b00, sb = 2'b00, imm = 2'b00;
        logic [2:0] alu = 3'b000;
        logic       funct_alu = 1'b0;
        case (st)
            T_FETCH:    begin irw = 1'b1; sb = 2'b10; res = 2'b10; pcw = 1'b1; end
            T_DECODE:   begin sa = 2'b01; sb = 2'b01; end
            T_MEMADR:   begin sa = 2'b10; sb = 2'b01; end
            T_MEMREAD:  adr = 1'b1;
            T_MEMWRITE: begin adr = 1'b1; mw = 1'b1; end
            T_MEMWB:    begin res = 2'b01; rw = 1'b1; end
            T_EXECUTER: begin sa = 2'b10; funct_alu = 1'b1; end
            T_EXECUTEI: begin sa = 2'b10; sb = 2'b01; funct_alu = 1'b1; end
            T_ALUWB:    rw = 1'b1;
            T_BEQ:      begin sa = 2'b10; alu = 3'b001; pcw = Zero; end
            T_JAL:      begin sa = 2'b01; sb = 2'b10; pcw = 1'b1; end
            default:    ;
        endcase
        if (funct_alu) begin
            case (funct3)
                3'b000:  alu = (op[5] && funct7b5) ? 3'b001 : 3'b000;
                3'b010:  alu = 3'b101;
                3'b110:  alu = 3'b011;
                3'b111:  alu = 3'b010;
                default: alu = 3'b000;
            endcase
        end
        if (op == 7'b0100011)      imm = 2'b01;
        else if (op == 7'b1100011) imm = 2'b10;
        else if (op == 7'b1101111) imm = 2'b11;
        return {pcw, adr, mw, irw, rw, res, sa, sb, imm, alu};
    endfunction

    // Push the expectation for the current cycle, compare on the falling
    // edge, then advance to just after the next rising edge.
    task automatic step(input tst_t st, input string tag);
        sb_t         e;
        sb_t         got;
        logic [15:0] obs;
        e.exp = model(st);
        e.tag = tag;
        sbq.push_back(e);
        @(negedge clk);
        got = sbq.pop_front();
        obs = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ImmSrc, ALUControl};
        checks++;
        assert (obs === got.exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", got.tag, obs, got.exp);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [6:0] o, input logic [2:0] f3,
                             input logic f7, input logic z);
        op       = o;
        funct3   = f3;
        funct7b5 = f7;
        Zero     = z;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        set_instr(7'b0000000, 3'b000, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        step(T_FETCH, "reset_hold");
        reset = 1'b0;

        // lw: 5 cycles
        set_instr(7'b0000011, 3'b010, 1'b0, 1'b0);
        step(T_FETCH,   "lw_fetch");
        step(T_DECODE,  "lw_decode");
        step(T_MEMADR,  "lw_memadr");
        step(T_MEMREAD, "lw_memread");
        step(T_MEMWB,   "lw_memwb");

        // sub
        set_instr(7'b0110011, 3'b000, 1'b1, 1'b0);
        step(T_FETCH,    "sub_fetch");
        step(T_DECODE,   "sub_decode");
        step(T_EXECUTER, "sub_exec");
        step(T_ALUWB,    "sub_aluwb");

        // add (bit 30 clear)
        set_instr(7'b0110011, 3'b000, 1'b0, 1'b0);
        step(T_FETCH,    "add_fetch");
        step(T_DECODE,   "add_decode");
        step(T_EXECUTER, "add_exec");
        step(T_ALUWB,    "add_aluwb");

        // or, and, unsupported funct3
        set_instr(7'b0110011, 3'b110, 1'b0, 1'b0);
        step(T_FETCH,    "or_fetch");
        step(T_DECODE,   "or_decode");
        step(T_EXECUTER, "or_exec");
        step(T_ALUWB,    "or_aluwb");
        set_instr(7'b0010011, 3'b111, 1'b0, 1'b0);
        step(T_FETCH,    "andi_fetch");
        step(T_DECODE,   "andi_decode");
        step(T_EXECUTEI, "andi_exec");
        step(T_ALUWB,    "andi_aluwb");
        set_instr(7'b0110011, 3'b001, 1'b1, 1'b0);
        step(T_FETCH,    "f3other_fetch");
        step(T_DECODE,   "f3other_decode");
        step(T_EXECUTER, "f3other_exec");
        step(T_ALUWB,    "f3other_aluwb");

        // addi with bit 30 set must still add
        set_instr(7'b0010011, 3'b000, 1'b1, 1'b0);
        step(T_FETCH,    "addi_fetch");
        step(T_DECODE,   "addi_decode");
        step(T_EXECUTEI, "addi_exec");
        step(T_ALUWB,    "addi_aluwb");

        // slti
        set_instr(7'b0010011, 3'b010, 1'b0, 1'b0);
        step(T_FETCH,    "slti_fetch");
        step(T_DECODE,   "slti_decode");
        step(T_EXECUTEI, "slti_exec");
        step(T_ALUWB,    "slti_aluwb");

        // sw
        set_instr(7'b0100011, 3'b010, 1'b0, 1'b0);
        step(T_FETCH,    "sw_fetch");
        step(T_DECODE,   "sw_decode");
        step(T_MEMADR,   "sw_memadr");
        step(T_MEMWRITE, "sw_memwrite");

        // beq taken then not taken
        set_instr(7'b1100011, 3'b000, 1'b0, 1'b1);
        step(T_FETCH,  "beq_t_fetch");
        step(T_DECODE, "beq_t_decode");
        step(T_BEQ,    "beq_taken");
        set_instr(7'b1100011, 3'b000, 1'b0, 1'b0);
        step(T_FETCH,  "beq_n_fetch");
        step(T_DECODE, "beq_n_decode");
        step(T_BEQ,    "beq_not_taken");

        // jal
        set_instr(7'b1101111, 3'b000, 1'b0, 1'b0);
        step(T_FETCH,  "jal_fetch");
        step(T_DECODE, "jal_decode");
        step(T_JAL,    "jal_jal");
        step(T_ALUWB,  "jal_aluwb");

        // illegal opcode returns to FETCH with no strobes
        set_instr(7'b1111111, 3'b000, 1'b0, 1'b0);
        step(T_FETCH,  "ill_fetch");
        step(T_DECODE, "ill_decode");

        // lw interrupted by reset in MEMREAD
        set_instr(7'b0000011, 3'b010, 1'b0, 1'b0);
        step(T_FETCH,  "ill_next_fetch");
        step(T_DECODE, "lwr_decode");
        step(T_MEMADR, "lwr_memadr");
        reset = 1'b1;
        step(T_FETCH,  "lwr_reset_in_memread");
        reset = 1'b0;
        step(T_FETCH,   "lwr_after_reset");
        step(T_DECODE,  "lwr2_decode");
        step(T_MEMADR,  "lwr2_memadr");
        step(T_MEMREAD, "lwr2_memread");
        step(T_MEMWB,   "lwr2_memwb");
        step(T_FETCH,   "final_fetch");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 The block SHALL have the following ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- op  in  7  instruction opcode field.
- funct3  in  3  instruction funct3 field.
- funct7b5  in  1  instruction bit 30.
- Zero  in  1  ALU zero flag.
- PCWrite  out  1  PC register enable.
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemWrite  out  1  data memory write strobe.
- IRWrite  out  1  instruction register enable.
- RegWrite  out  1  register file write enable.
- ResultSrc  out  2  result mux select: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- ALUSrcA  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1 data.
- ALUSrcB  out  2  ALU B select: 00 = rs2 data, 01 = ImmExt, 10 = constant 4.
- ImmSrc  out  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J.
- ALUControl  out  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 101 slt.

Function
REQ-002 The block SHALL be a Moore FSM with 11 states: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BEQ, JAL.
REQ-003 Transitions, one per clock edge:
- FETCH->DECODE.
- DECODE: op 0000011 or 0100011 -> MEMADR; 0110011 -> EXECUTER; 0010011 -> EXECUTEI; 1100011 -> BEQ; 1101111 -> JAL; any other op -> FETCH.
- MEMADR: 0000011 -> MEMREAD, else MEMWRITE.
- MEMREAD->MEMWB.
- EXECUTER and EXECUTEI -> ALUWB.
- JAL->ALUWB.
- MEMWB, MEMWRITE, ALUWB, BEQ -> FETCH.
REQ-004 Per-state outputs (unlisted enables 0, unlisted selects 00, ALUOp 00):
- FETCH: IRWrite=1, ALUSrcB=10, ResultSrc=10, PCUpdate=1.
- DECODE: ALUSrcA=01, ALUSrcB=01.
- MEMADR: ALUSrcA=10, ALUSrcB=01.
- MEMREAD: AdrSrc=1.
- MEMWRITE: AdrSrc=1, MemWrite=1.
- MEMWB: ResultSrc=01, RegWrite=1.
- EXECUTER: ALUSrcA=10, ALUOp=10.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10.
- ALUWB: RegWrite=1.
- BEQ: ALUSrcA=10, ALUOp=01, Branch=1.
- JAL: ALUSrcA=01, ALUSrcB=10, PCUpdate=1.
REQ-005 PCWrite SHALL equal PCUpdate OR (Branch AND Zero), combinationally within the same cycle.
REQ-006 ALUControl SHALL decode as follows:
- ALUOp 00 -> 000; ALUOp 01 -> 001.
- ALUOp 10 by funct3: 000 -> 001 if (op[5] AND funct7b5) else 000; 010 -> 101; 110 -> 011; 111 -> 010; other -> 000.
REQ-007 ImmSrc SHALL be combinational from op: 0100011 -> 01; 1100011 -> 10; 1101111 -> 11; all others -> 00.
REQ-008 An unsupported op SHALL cause no write strobe; the FSM SHALL return to FETCH one cycle after DECODE.
REQ-009 Instruction latency SHALL be: lw 5 cycles; sw, R-type, I-type and jal 4 cycles; beq 3 cycles.

Reset
REQ-010 When reset is high at a clock edge, the state SHALL become FETCH regardless of current state, including mid-instruction.
REQ-011 While in reset and on the first cycle after it, the outputs SHALL be the FETCH values: IRWrite=1, PCWrite=1, ALUSrcB=10, ResultSrc=10, ALUControl=000, all other outputs 0.

Structure
REQ-012 A shared package SHALL hold the opcode constants, the state enumeration, the ALUOp codes and the ALUControl codes; ALU and controller SHALL both use it.
REQ-013 ALUControl decoding SHALL be a combinational sub-module named alu_decoder; the FSM and output logic remain in multicycle_controller.

Verification
REQ-014 The bench SHALL cover:
- lw (op 0000011): reset then 5 cycles -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB; RegWrite=1 only in MEMWB, ResultSrc=01.
- sub (op 0110011, funct3 000, funct7b5=1): in EXECUTER -> ALUControl=001; in ALUWB -> RegWrite=1; next state FETCH.
- slt immediate (op 0010011, funct3 010): in EXECUTEI -> ALUControl=101, ALUSrcB=01.
- beq with Zero=1 then Zero=0: in BEQ -> PCWrite=1 then 0 respectively; ALUControl=001, ImmSrc=10.
- Illegal op 1111111: DECODE -> FETCH with no MemWrite or RegWrite asserted.
- reset asserted during MEMREAD -> FETCH on the next edge with the REQ-011 outputs.
